// File: rtl/jtdsp16_sout_pkg.sv
// Shared types and helpers for the DSP16 serial-output receiver.
package jtdsp16_sout_pkg;

   typedef enum logic {IDLE, SHIFT} rx_state_t;
   typedef enum logic {CH_L, CH_R} chan_t;

   // Counter is sized for the longest supported word so the package stays parameter-free
   localparam int MAX_WORDLEN = 16;
   localparam int CNTW        = $clog2(MAX_WORDLEN + 1);

   function automatic logic [15:0] left_align(input logic [15:0] w, input int len);
      return w << (16 - len);
   endfunction

endpackage

// File: rtl/jtdsp16_sout_shift.sv
// Serial word receiver: ock edge detect, MSB-first shifter, bit counter and framing check.
module jtdsp16_sout_shift
   import jtdsp16_sout_pkg::*;
#(
   parameter int   WORDLEN   = 16,
   parameter logic LEFT_SADD = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        sdo,
   input  logic        ock,
   input  logic        old,
   input  logic        sadd,
   output logic        word_done,
   output logic [15:0] word_data,
   output chan_t       word_chan,
   output logic        frame_restart
);

   localparam logic [CNTW-1:0] FULL = CNTW'(WORDLEN);

   logic            ock_l;
   rx_state_t       state;
   logic [CNTW-1:0] cnt;
   logic [15:0]     shift_reg;
   chan_t           chan;

   logic bit_ev;
   logic full;
   logic start;

   assign bit_ev        = cen & ock & ~ock_l;
   assign full          = (state == SHIFT) && (cnt == FULL);
   assign start         = bit_ev & old;
   assign word_done     = cen & full;
   assign frame_restart = start & (state == SHIFT) & ~full;
   // Upper bits above WORDLEN are always zero, shift left-aligns into 16 bits
   assign word_data     = left_align(shift_reg, WORDLEN);
   assign word_chan     = chan;

   always_ff @(posedge clk) begin
      if (rst) begin
         ock_l     <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         shift_reg <= '0;
         chan      <= CH_L;
      end else if (cen) begin
         ock_l <= ock;
         if (start) begin
            shift_reg <= {15'd0, sdo};
            cnt       <= CNTW'(1);
            chan      <= (sadd == LEFT_SADD) ? CH_L : CH_R;
            state     <= SHIFT;
         end else if (full) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (bit_ev && state == SHIFT) begin
            shift_reg <= {shift_reg[14:0], sdo};
            cnt       <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/jtdsp16_sout.sv
// DSP16 serial output consumer: pairs left/right words and hands stereo samples to the mixer.
module jtdsp16_sout
   import jtdsp16_sout_pkg::*;
#(
   parameter int   WORDLEN   = 16,
   parameter logic LEFT_SADD = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        sdo,
   input  logic        ock,
   input  logic        old,
   input  logic        sadd,
   output logic [15:0] snd_left,
   output logic [15:0] snd_right,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        frame_err,
   output logic        overrun,
   input  logic        clr_err
);

   logic        word_done;
   logic [15:0] word_data;
   chan_t       word_chan;
   logic        frame_restart;

   logic [15:0] left_hold;
   logic        left_pend;
   logic        pair_load;
   logic        frame_ev;
   logic        over_ev;

   jtdsp16_sout_shift #(
      .WORDLEN   (WORDLEN),
      .LEFT_SADD (LEFT_SADD)
   ) u_shift (
      .clk           (clk),
      .rst           (rst),
      .cen           (cen),
      .sdo           (sdo),
      .ock           (ock),
      .old           (old),
      .sadd          (sadd),
      .word_done     (word_done),
      .word_data     (word_data),
      .word_chan     (word_chan),
      .frame_restart (frame_restart)
   );

   assign pair_load = word_done & (word_chan == CH_R) & left_pend;
   assign frame_ev  = frame_restart
                    | (word_done & (word_chan == CH_L) &  left_pend)
                    | (word_done & (word_chan == CH_R) & ~left_pend);
   assign over_ev   = pair_load & sample_valid & ~sample_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         left_hold    <= '0;
         left_pend    <= 1'b0;
         snd_left     <= '0;
         snd_right    <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (word_done && word_chan == CH_L) begin
            left_hold <= word_data;
            left_pend <= 1'b1;
         end
         // A pair loading in the same cycle as an accept keeps valid high
         if (pair_load) begin
            snd_left     <= left_hold;
            snd_right    <= word_data;
            sample_valid <= 1'b1;
            left_pend    <= 1'b0;
         end else if (cen && sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
         end
         // Error events take priority over clearing; clearing ignores cen
         if (frame_ev)     frame_err <= 1'b1;
         else if (clr_err) frame_err <= 1'b0;
         if (over_ev)      overrun   <= 1'b1;
         else if (clr_err) overrun   <= 1'b0;
      end
   end

endmodule

// File: doc/jtdsp16_sout.md
Name: jtdsp16_sout

Overview:
- Downstream consumer of the DSP16 serial output pins (sdo, ock, old, sadd).
- Deserialises 16-bit MSB-first words and sorts them into left/right channels using sadd.
- Presents completed stereo pairs on a valid/ready interface to the sound mixer.
- Flags framing and overrun errors for debug.

Parameters:
- WORDLEN, 16, bits per serial word (supported range 8..16).
- LEFT_SADD, 0, sadd value sampled at bit 0 that selects the left channel.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- cen  input  1  clock enable; connect to cen_cko. All state updates are gated by it.
- sdo  input  1  serial data from DSP16.
- ock  input  1  serial output clock from DSP16. Synchronous to clk; no synchroniser.
- old  input  1  output load. High during the first bit of a word.
- sadd  input  1  serial address; selects the channel.
- snd_left  output  16  left sample of the last completed pair.
- snd_right  output  16  right sample of the last completed pair.
- sample_valid  output  1  a pair is held and has not yet been taken.
- sample_ready  input  1  consumer accepts the pair when valid and ready are both high.
- frame_err  output  1  sticky framing error.
- overrun  output  1  sticky overrun error.
- clr_err  input  1  clears frame_err and overrun.

Behaviour:
- Edge detect: ock_l is ock registered on cen. A bit event is cen & ock & ~ock_l. Nothing else advances the shifter.
- Reset values:
  - snd_left = 0, snd_right = 0.
  - sample_valid = 0, frame_err = 0, overrun = 0.
  - ock_l = 1, so a high ock present at reset is not counted as an edge.
  - Receiver state = IDLE, bit counter = 0, left_pend = 0.
- IDLE state:
  - Bit event with old=1: shift ← sdo into the LSB, cnt = 1, chan latched from sadd (chan = sadd==LEFT_SADD ? L : R), go to SHIFT.
  - Bit event with old=0: ignored, stay in IDLE.
- SHIFT state:
  - Bit event with old=0: shift = {shift[WORDLEN-2:0], sdo}, cnt + 1.
  - Bit event with old=1 while cnt < WORDLEN: set frame_err. Restart the word exactly as the IDLE case, discarding the partial word.
- Word complete (cnt reaches WORDLEN): takes effect the clk after the final bit event. Return to IDLE.
  - chan = L: store into left holding register, set left_pend = 1. A second L word while left_pend is set replaces the held value and sets frame_err.
  - chan = R with left_pend = 1: load snd_left ← holding, snd_right ← word, set sample_valid, clear left_pend.
  - chan = R with left_pend = 0: set frame_err, discard the word.
- Output handshake:
  - Latency from the last right-channel ock rising edge to sample_valid is 2 clk cycles with cen high.
  - snd_left and snd_right are stable while sample_valid = 1.
  - valid & ready: sample_valid clears on the next cen, unless a new pair loads in that same cycle. Then the new pair loads, sample_valid stays 1 and overrun is not set.
  - New pair while valid & ~ready: overwrite both samples, keep sample_valid = 1, set overrun.
- Error flags:
  - Sticky until clr_err or rst.
  - clr_err takes effect without cen.
  - If an error event and clr_err occur in the same cycle, the error wins (flag stays 1).
- sample_ready is only observed on cen cycles.
- rst mid-word discards all partial state. The next word starts only on old=1.
- Width rule: WORDLEN < 16 results are left-aligned in the 16-bit outputs, with zero-filled LSBs.

Decomposition:
- Shared package jtdsp16_sout_pkg holds:
  - receiver state enum {IDLE, SHIFT};
  - channel enum {CH_L, CH_R};
  - localparam CNTW = $clog2(WORDLEN+1).
- One sub-module is natural: jtdsp16_sout_shift.
  - Contains the edge detector, shifter, counter and framing check.
  - Outputs word_done, word_data and word_chan.
- The top level keeps the channel pairing, holding registers, handshake and error flags.

Test Plan:
- Pair capture: L=0x1234 with sadd=0, then R=0xABCD with sadd=1, ready=1 -> one sample_valid pulse 2 clk after the last ock edge; snd_left=0x1234, snd_right=0xABCD; no flags set.
- Backpressure: ready=0 across two pairs, (0x0001, 0x0002) then (0x0003, 0x0004) -> outputs 0x0003/0x0004, sample_valid stays 1, overrun=1. Then ready=1 -> valid drops; clr_err clears overrun.
- Framing restart: old pulses again after 7 bits of a word, followed by a full L=0x8001 and R=0x7FFE -> frame_err=1, pair delivered as 0x8001/0x7FFE.
- Orphan right word: R word 0x5555 with no preceding L -> frame_err=1, sample_valid stays 0. The next normal pair is delivered correctly.
- Reset mid-word: assert rst after 9 bits, release, then send a full pair 0x0F0F/0xF0F0 -> the first output is exactly 0x0F0F/0xF0F0, and all outputs read 0 during reset.
- cen gating: hold cen=0 while ock toggles 16 times -> no state change. Then with cen toggling every other clk, a full pair is captured correctly.
